// File: rtl/input_fetch_master_pkg.sv
// Shared AXI constants and fetch FSM state type for the input fetch master.
package input_fetch_master_pkg;

   localparam int AXI_ADDR_W  = 32;
   localparam int AXI_DATA_W  = 32;
   localparam int AXI_ID_W    = 4;
   localparam int AXI_LEN_W   = 4;
   localparam int AXI_SIZE_W  = 3;
   localparam int AXI_BURST_W = 2;
   localparam int AXI_RESP_W  = 2;

   localparam logic [AXI_BURST_W-1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [AXI_SIZE_W-1:0]  AXI_SIZE_WORD  = 3'b010;
   localparam logic [AXI_RESP_W-1:0]  AXI_RESP_OKAY  = 2'b00;

   typedef enum logic [2:0] {
      IDLE,
      AR,
      R,
      DRAIN,
      DONE
   } fetch_state_t;

endpackage

// File: rtl/input_fetch_master_if.sv
// AXI4 read-channel bundle (plus write-side tie-offs) between fetch master and interconnect.
interface input_fetch_master_if;
   import input_fetch_master_pkg::*;

   logic [AXI_ID_W-1:0]    arid;
   logic [AXI_ADDR_W-1:0]  araddr;
   logic [AXI_LEN_W-1:0]   arlen;
   logic [AXI_SIZE_W-1:0]  arsize;
   logic [AXI_BURST_W-1:0] arburst;
   logic                   arvalid;
   logic                   arready;

   logic [AXI_ID_W-1:0]    rid;
   logic [AXI_DATA_W-1:0]  rdata;
   logic [AXI_RESP_W-1:0]  rresp;
   logic                   rlast;
   logic                   rvalid;
   logic                   rready;

   logic                   awvalid;
   logic                   wvalid;
   logic                   bready;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready,
      output awvalid, wvalid, bready
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready,
      input  awvalid, wvalid, bready
   );

endinterface

// File: rtl/input_fetch_master_skid_buf.sv
// Two-entry registered valid/ready buffer; output valid one cycle after a push.
module stream_skid_buf #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             empty
);

   logic [WIDTH-1:0] mem [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic [1:0]       count;
   logic             push;
   logic             pop;

   assign in_ready  = (count != 2'd2);
   assign out_valid = (count != 2'd0);
   assign empty     = (count == 2'd0);
   assign out_data  = mem[rd_ptr];
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= in_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

endmodule

// File: rtl/input_fetch_master.sv
// AXI4 read master: fetches num_words 32-bit words from src_addr in 4 KB-safe INCR
// bursts, one burst outstanding, and streams them out through a 2-entry skid buffer.
//
// state | meaning
// IDLE  | waiting for start
// AR    | presenting read address for the next burst
// R     | accepting read beats into the skid buffer
// DRAIN | all beats received, waiting for the skid to empty
// DONE  | one-cycle completion pulse
module input_fetch_master
   import input_fetch_master_pkg::*;
#(
   parameter logic [AXI_ID_W-1:0] MASTER_ID = 4'h1,
   parameter int                  MAX_BURST = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [AXI_ADDR_W-1:0]   src_addr,
   input  logic [15:0]             num_words,
   output logic                    busy,
   output logic                    done,
   output logic                    err,
   input_fetch_master_if.master    axi,
   output logic [AXI_DATA_W-1:0]   out_data,
   output logic                    out_valid,
   input  logic                    out_ready
);

   fetch_state_t          state;
   fetch_state_t          state_nx;
   logic [AXI_ADDR_W-1:0] addr;
   logic [15:0]           remaining;
   logic [4:0]            beat_cnt;
   logic [4:0]            burst_len;
   logic [4:0]            beats;
   logic [16:0]           rem17;
   logic [16:0]           room17;
   logic [16:0]           beats17;
   logic                  skid_in_valid;
   logic                  skid_in_ready;
   logic                  skid_empty;
   logic                  push_beat;
   logic                  last_beat;
   logic                  bad_beat;
   logic                  unused_bits;

   // Burst size limited by words left, MAX_BURST and the words left in this 4 KB page.
   always_comb begin
      rem17   = {1'b0, remaining};
      room17  = (17'd4096 - {5'd0, addr[11:0]}) >> 2;
      beats17 = rem17;
      if (beats17 > 17'(MAX_BURST)) beats17 = 17'(MAX_BURST);
      if (beats17 > room17)         beats17 = room17;
   end

   assign beats         = beats17[4:0];
   assign skid_in_valid = (state == R) && axi.rvalid;
   assign push_beat     = skid_in_valid && skid_in_ready;
   assign last_beat     = push_beat && (beat_cnt == 5'd1);
   assign bad_beat      = (axi.rresp != AXI_RESP_OKAY) || (axi.rlast != (beat_cnt == 5'd1));
   assign unused_bits   = ^{axi.rid, src_addr[1:0], beats17[16:5]};

   assign axi.arid    = MASTER_ID;
   assign axi.arsize  = AXI_SIZE_WORD;
   assign axi.arburst = AXI_BURST_INCR;
   assign axi.araddr  = addr;
   assign axi.arlen   = (state == AR) ? AXI_LEN_W'(beats - 5'd1) : '0;
   assign axi.awvalid = 1'b0;
   assign axi.wvalid  = 1'b0;
   assign axi.bready  = 1'b1;

   always_comb begin
      state_nx    = state;
      busy        = 1'b1;
      done        = 1'b0;
      axi.arvalid = 1'b0;
      axi.rready  = 1'b0;
      unique case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_nx = (num_words == 16'd0) ? DONE : AR;
         end
         AR: begin
            axi.arvalid = 1'b1;
            if (axi.arready) state_nx = R;
         end
         R: begin
            axi.rready = skid_in_ready;
            if (last_beat) state_nx = (remaining == 16'd1) ? DRAIN : AR;
         end
         DRAIN: begin
            if (skid_empty) state_nx = DONE;
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         addr      <= '0;
         remaining <= '0;
         beat_cnt  <= '0;
         burst_len <= '0;
         err       <= 1'b0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: begin
               if (start) begin
                  err       <= 1'b0;
                  addr      <= {src_addr[AXI_ADDR_W-1:2], 2'b00};
                  remaining <= num_words;
               end
            end
            AR: begin
               if (axi.arready) begin
                  beat_cnt  <= beats;
                  burst_len <= beats;
               end
            end
            R: begin
               // Beat count alone ends the burst; a bad rresp or misplaced rlast only flags err.
               if (push_beat) begin
                  beat_cnt  <= beat_cnt - 5'd1;
                  remaining <= remaining - 16'd1;
                  if (bad_beat) err <= 1'b1;
                  if (beat_cnt == 5'd1) addr <= addr + {25'd0, burst_len, 2'b00};
               end
            end
            default: ;
         endcase
      end
   end

   stream_skid_buf #(
      .WIDTH(AXI_DATA_W)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (skid_in_valid),
      .in_ready  (skid_in_ready),
      .in_data   (axi.rdata),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .empty     (skid_empty)
   );

endmodule
